sha_k_sequencer: RTL and testbench
==================================

Name: sha_k_sequencer

Overview:
Parametrised round-constant sequencer for the SHA-2 compression core; successor to the fixed 32-bit free-running K register. It delivers SHA-256 (64 x 32-bit) or SHA-512 (80 x 64-bit) round constants under a start/advance handshake. It supports stall, abort and a one-word lookahead, and flags the last round and completion. It sits between the control FSM and the round datapath.

Parameters:
WORD_W, 32, constant width. Only 32 (SHA-256 table, 64 rounds) or 64 (SHA-512 table, 80 rounds) are legal; any other value is an elaboration error.
ROUNDS (localparam), 64 when WORD_W=32 and 80 when WORD_W=64, sequence length.
IDX_W (localparam), 7, width of the round index.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins or restarts the sequence at round 0
abort  in  1  one-cycle pulse; cancels the sequence and returns to idle
k_adv  in  1  consumer accepted k_out this cycle
k_out  out  WORD_W  current constant K[round_idx]
k_next  out  WORD_W  lookahead constant K[round_idx+1]
k_valid  out  1  k_out and round_idx are valid
round_idx  out  IDX_W  current round number, 0..ROUNDS-1
k_last  out  1  k_valid and round_idx==ROUNDS-1
busy  out  1  sequence active (equals k_valid)
done  out  1  one-cycle pulse after the final constant is accepted

Behaviour:
- Clocking and reset: one clock (clk); reset rst is asynchronous, active-low.
- Reset values: all outputs 0, internal state IDLE.
- States:
  - IDLE: k_valid=0; k_out, k_next and round_idx are driven to 0.
  - RUN: k_valid=1.
- Registered outputs: all outputs are registered, with no combinational path from inputs to outputs.
- Start latency: start sampled high at edge t gives k_valid=1, round_idx=0, k_out=K[0] and k_next=K[1] after edge t.
- Handshake:
  - In RUN, an edge with k_adv=1 advances round_idx by 1 and loads K[idx+1] into k_out and K[idx+2] into k_next.
  - k_adv=0 holds every output unchanged (stall). Unlike the old block, stalling never zeroes k_out or resets the index.
- Throughput: k_adv held high steps one constant per cycle.
- k_next at the boundary: k_next=0 whenever round_idx==ROUNDS-1 or k_valid=0.
- Final word: k_adv while k_last=1 moves to IDLE. At that edge k_valid drops, outputs clear and done=1 for exactly one cycle. No wrap back to K[0].
- k_adv in IDLE: ignored, no effect.
- Priority at the same edge: abort > start > k_adv.
  - abort in any state: go to IDLE, clear outputs, no done.
  - abort and start together: abort wins and start is dropped.
  - start in RUN (restart): go to round 0 with K[0]/K[1]. done is not asserted, even if k_adv and k_last were high that edge.
- Reset mid-sequence: asynchronous clear to IDLE with all outputs 0 immediately; no done.
- Arithmetic: round_idx is an unsigned IDX_W-bit counter. It never exceeds ROUNDS-1. The table index for k_next is computed in IDX_W bits, so there is no truncation at 63 or 79.
- Constant tables: the FIPS 180-4 SHA-256 K table (WORD_W=32) or the SHA-512 K table (WORD_W=64), held as a synthesizable case-ROM. Initial blocks are not used.

Test Plan:
- Reset/idle (WORD_W=32): assert rst=0 mid-run -> all outputs 0 immediately; after release with no start, k_valid stays 0 for 10 cycles.
- Full stream (WORD_W=32): start then k_adv=1 continuously -> k_out K[0]=428a2f98 with k_next=71374491, through K[63]=c67178f2 with k_last=1 and k_next=0. done pulses once on the next cycle; k_valid=0 afterwards.
- Stall: at round 5 (k_out=59f111f1) drop k_adv for 4 cycles -> all outputs are frozen; on resume k_out=923f82a4, round_idx=6.
- SHA-512 (WORD_W=64): full stream -> K[0]=428a2f98d728ae22, K[1]=7137449123ef65cd; K[79]=6c44198c4a475817 with round_idx=79 and k_last=1; then done pulses; 80 accepts in total.
- Abort/restart: abort at round 20 -> IDLE, no done. start at round 30 with k_adv=1 -> next cycle round_idx=0, k_out=428a2f98. start and abort in the same cycle -> IDLE.
- Last-word collision: start with k_adv while k_last=1 -> restart at round 0 and done stays 0. k_adv pulses in IDLE -> no state change.

Source files
------------

// File: rtl/sha_k_sequencer_if.sv
// Handshake bundle between the SHA-2 control FSM / round datapath and the K sequencer.
// The master side issues start/abort/k_adv and consumes the constants.
interface sha_k_sequencer_if #(
   parameter int WORD_W = 32,
   parameter int IDX_W  = 7
);
   logic              start;
   logic              abort;
   logic              k_adv;
   logic [WORD_W-1:0] k_out;
   logic [WORD_W-1:0] k_next;
   logic              k_valid;
   logic [IDX_W-1:0]  round_idx;
   logic              k_last;
   logic              busy;
   logic              done;

   modport master (
      output start, abort, k_adv,
      input  k_out, k_next, k_valid, round_idx, k_last, busy, done
   );

   modport slave (
      input  start, abort, k_adv,
      output k_out, k_next, k_valid, round_idx, k_last, busy, done
   );
endinterface

// File: rtl/sha_k_sequencer.sv
// SHA-256 / SHA-512 round-constant sequencer with start/abort/advance handshake,
// one-word lookahead, last-round flag and completion pulse. All outputs come from registers.
module sha_k_sequencer #(
   parameter int WORD_W = 32
) (
   input logic             clk,
   input logic             rst,
   sha_k_sequencer_if.slave bus
);
   localparam int IDX_W  = 7;
   localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

   if (WORD_W != 32 && WORD_W != 64) begin : g_badWidth
      $error("sha_k_sequencer: WORD_W must be 32 or 64");
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic [WORD_W-1:0]  r_kOut;
   logic [WORD_W-1:0]  r_kNext;
   logic               r_done;

   state_t             w_stateNext;
   logic [IDX_W-1:0]   w_idxNext;
   logic [WORD_W-1:0]  w_kOutNext;
   logic [WORD_W-1:0]  w_kNextNext;
   logic               w_doneNext;
   logic [IDX_W-1:0]   w_idxPlus1;
   logic [IDX_W-1:0]   w_idxPlus2;

   // The SHA-256 constants are exactly the upper 32 bits of the first 64 SHA-512
   // constants, so one 64-bit ROM serves both widths; indices past the end read 0.
   function automatic logic [WORD_W-1:0] kRom(input logic [IDX_W-1:0] idx);
      logic [63:0] w_full;
      case (idx)
         7'd0:  w_full = 64'h428a2f98d728ae22;
         7'd1:  w_full = 64'h7137449123ef65cd;
         7'd2:  w_full = 64'hb5c0fbcfec4d3b2f;
         7'd3:  w_full = 64'he9b5dba58189dbbc;
         7'd4:  w_full = 64'h3956c25bf348b538;
         7'd5:  w_full = 64'h59f111f1b605d019;
         7'd6:  w_full = 64'h923f82a4af194f9b;
         7'd7:  w_full = 64'hab1c5ed5da6d8118;
         7'd8:  w_full = 64'hd807aa98a3030242;
         7'd9:  w_full = 64'h12835b0145706fbe;
         7'd10: w_full = 64'h243185be4ee4b28c;
         7'd11: w_full = 64'h550c7dc3d5ffb4e2;
         7'd12: w_full = 64'h72be5d74f27b896f;
         7'd13: w_full = 64'h80deb1fe3b1696b1;
         7'd14: w_full = 64'h9bdc06a725c71235;
         7'd15: w_full = 64'hc19bf174cf692694;
         7'd16: w_full = 64'he49b69c19ef14ad2;
         7'd17: w_full = 64'hefbe4786384f25e3;
         7'd18: w_full = 64'h0fc19dc68b8cd5b5;
         7'd19: w_full = 64'h240ca1cc77ac9c65;
         7'd20: w_full = 64'h2de92c6f592b0275;
         7'd21: w_full = 64'h4a7484aa6ea6e483;
         7'd22: w_full = 64'h5cb0a9dcbd41fbd4;
         7'd23: w_full = 64'h76f988da831153b5;
         7'd24: w_full = 64'h983e5152ee66dfab;
         7'd25: w_full = 64'ha831c66d2db43210;
         7'd26: w_full = 64'hb00327c898fb213f;
         7'd27: w_full = 64'hbf597fc7beef0ee4;
         7'd28: w_full = 64'hc6e00bf33da88fc2;
         7'd29: w_full = 64'hd5a79147930aa725;
         7'd30: w_full = 64'h06ca6351e003826f;
         7'd31: w_full = 64'h142929670a0e6e70;
         7'd32: w_full = 64'h27b70a8546d22ffc;
         7'd33: w_full = 64'h2e1b21385c26c926;
         7'd34: w_full = 64'h4d2c6dfc5ac42aed;
         7'd35: w_full = 64'h53380d139d95b3df;
         7'd36: w_full = 64'h650a73548baf63de;
         7'd37: w_full = 64'h766a0abb3c77b2a8;
         7'd38: w_full = 64'h81c2c92e47edaee6;
         7'd39: w_full = 64'h92722c851482353b;
         7'd40: w_full = 64'ha2bfe8a14cf10364;
         7'd41: w_full = 64'ha81a664bbc423001;
         7'd42: w_full = 64'hc24b8b70d0f89791;
         7'd43: w_full = 64'hc76c51a30654be30;
         7'd44: w_full = 64'hd192e819d6ef5218;
         7'd45: w_full = 64'hd69906245565a910;
         7'd46: w_full = 64'hf40e35855771202a;
         7'd47: w_full = 64'h106aa07032bbd1b8;
         7'd48: w_full = 64'h19a4c116b8d2d0c8;
         7'd49: w_full = 64'h1e376c085141ab53;
         7'd50: w_full = 64'h2748774cdf8eeb99;
         7'd51: w_full = 64'h34b0bcb5e19b48a8;
         7'd52: w_full = 64'h391c0cb3c5c95a63;
         7'd53: w_full = 64'h4ed8aa4ae3418acb;
         7'd54: w_full = 64'h5b9cca4f7763e373;
         7'd55: w_full = 64'h682e6ff3d6b2b8a3;
         7'd56: w_full = 64'h748f82ee5defb2fc;
         7'd57: w_full = 64'h78a5636f43172f60;
         7'd58: w_full = 64'h84c87814a1f0ab72;
         7'd59: w_full = 64'h8cc702081a6439ec;
         7'd60: w_full = 64'h90befffa23631e28;
         7'd61: w_full = 64'ha4506cebde82bde9;
         7'd62: w_full = 64'hbef9a3f7b2c67915;
         7'd63: w_full = 64'hc67178f2e372532b;
         7'd64: w_full = 64'hca273eceea26619c;
         7'd65: w_full = 64'hd186b8c721c0c207;
         7'd66: w_full = 64'heada7dd6cde0eb1e;
         7'd67: w_full = 64'hf57d4f7fee6ed178;
         7'd68: w_full = 64'h06f067aa72176fba;
         7'd69: w_full = 64'h0a637dc5a2c898a6;
         7'd70: w_full = 64'h113f9804bef90dae;
         7'd71: w_full = 64'h1b710b35131c471b;
         7'd72: w_full = 64'h28db77f523047d84;
         7'd73: w_full = 64'h32caab7b40c72493;
         7'd74: w_full = 64'h3c9ebe0a15c9bebc;
         7'd75: w_full = 64'h431d67c49c100d4c;
         7'd76: w_full = 64'h4cc5d4becb3e42b6;
         7'd77: w_full = 64'h597f299cfc657e2a;
         7'd78: w_full = 64'h5fcb6fab3ad6faec;
         7'd79: w_full = 64'h6c44198c4a475817;
         default: w_full = 64'h0;
      endcase
      if (idx > LAST_IDX) w_full = 64'h0;
      return w_full[63 -: WORD_W];
   endfunction

   assign w_idxPlus1 = r_idx + IDX_W'(1);
   assign w_idxPlus2 = r_idx + IDX_W'(2);

   // Priority abort > start > k_adv; a restart on the last word suppresses done.
   always_comb begin
      w_stateNext = r_state;
      w_idxNext   = r_idx;
      w_kOutNext  = r_kOut;
      w_kNextNext = r_kNext;
      w_doneNext  = 1'b0;
      if (bus.abort) begin
         w_stateNext = IDLE;
         w_idxNext   = '0;
         w_kOutNext  = '0;
         w_kNextNext = '0;
      end else if (bus.start) begin
         w_stateNext = RUN;
         w_idxNext   = '0;
         w_kOutNext  = kRom('0);
         w_kNextNext = kRom(IDX_W'(1));
      end else if (r_state == RUN && bus.k_adv) begin
         if (r_idx == LAST_IDX) begin
            w_stateNext = IDLE;
            w_idxNext   = '0;
            w_kOutNext  = '0;
            w_kNextNext = '0;
            w_doneNext  = 1'b1;
         end else begin
            w_idxNext   = w_idxPlus1;
            w_kOutNext  = kRom(w_idxPlus1);
            w_kNextNext = kRom(w_idxPlus2);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_kOut  <= '0;
         r_kNext <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_idx   <= w_idxNext;
         r_kOut  <= w_kOutNext;
         r_kNext <= w_kNextNext;
         r_done  <= w_doneNext;
      end
   end

   assign bus.k_valid   = (r_state == RUN);
   assign bus.busy      = (r_state == RUN);
   assign bus.k_last    = (r_state == RUN) && (r_idx == LAST_IDX);
   assign bus.round_idx = r_idx;
   assign bus.k_out     = r_kOut;
   assign bus.k_next    = r_kNext;
   assign bus.done      = r_done;
endmodule

// File: tb/tb_sha_k_sequencer.sv
// Directed bench for sha_k_sequencer: one 32-bit and one 64-bit instance sharing clock and reset.
module tb_sha_k_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   sha_k_sequencer_if #(.WORD_W(32)) bus32 ();
   sha_k_sequencer_if #(.WORD_W(64)) bus64 ();

   sha_k_sequencer #(.WORD_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
   sha_k_sequencer #(.WORD_W(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

   always #5 clk = ~clk;

   logic [31:0] k256 [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic [63:0] k512 [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
   };

   // Advance to just past the next rising edge so outputs are sampled away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start on the 32-bit instance, then accept n constants.
   task automatic startAndAdvance32(input int n);
      bus32.start = 1'b1;
      bus32.k_adv = 1'b0;
      tick();
      bus32.start = 1'b0;
      bus32.k_adv = 1'b1;
      for (int i = 0; i < n; i++) tick();
      bus32.k_adv = 1'b0;
   endtask

   // Bring the 32-bit instance back to idle with an abort pulse.
   task automatic abort32();
      bus32.abort = 1'b1;
      bus32.start = 1'b0;
      bus32.k_adv = 1'b0;
      tick();
      bus32.abort = 1'b0;
   endtask

   // Reset state of both instances, idle hold after release, and asynchronous reset mid-run.
   task automatic test_reset();
      #1;
      total++;
      if ({bus32.k_valid, bus32.busy, bus32.k_last, bus32.done, bus32.round_idx, bus32.k_out, bus32.k_next} !== '0) begin
         bad++;
         $display("[TB] FAIL reset32: got valid=%b idx=%0d kout=%h knext=%h done=%b want all zero",
                  bus32.k_valid, bus32.round_idx, bus32.k_out, bus32.k_next, bus32.done);
      end
      total++;
      if ({bus64.k_valid, bus64.busy, bus64.k_last, bus64.done, bus64.round_idx, bus64.k_out, bus64.k_next} !== '0) begin
         bad++;
         $display("[TB] FAIL reset64: got valid=%b idx=%0d kout=%h knext=%h done=%b want all zero",
                  bus64.k_valid, bus64.round_idx, bus64.k_out, bus64.k_next, bus64.done);
      end
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if ({bus32.k_valid, bus32.done, bus32.round_idx, bus32.k_out} !== '0) begin
            bad++;
            $display("[TB] FAIL idle_hold cycle %0d: got valid=%b done=%b idx=%0d kout=%h want 0",
                     i, bus32.k_valid, bus32.done, bus32.round_idx, bus32.k_out);
         end
      end
      startAndAdvance32(10);
      total++;
      if (bus32.k_valid !== 1'b1 || bus32.round_idx !== 7'd10 || bus32.k_out !== 32'h243185be) begin
         bad++;
         $display("[TB] FAIL prereset_run: got valid=%b idx=%0d kout=%h want 1 10 243185be",
                  bus32.k_valid, bus32.round_idx, bus32.k_out);
      end
      #2;
      rst = 1'b0;
      #1;
      total++;
      if ({bus32.k_valid, bus32.busy, bus32.k_last, bus32.done, bus32.round_idx, bus32.k_out, bus32.k_next} !== '0) begin
         bad++;
         $display("[TB] FAIL async_reset: got valid=%b idx=%0d kout=%h knext=%h done=%b want all zero",
                  bus32.k_valid, bus32.round_idx, bus32.k_out, bus32.k_next, bus32.done);
      end
      rst = 1'b1;
      tick();
      total++;
      if (bus32.k_valid !== 1'b0 || bus32.done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL post_reset: got valid=%b done=%b want 0 0", bus32.k_valid, bus32.done);
      end
   endtask

   // Start then continuous accept over all 64 SHA-256 constants, then done pulse.
   task automatic test_full_stream32();
      logic [31:0] expNext;
      bus32.start = 1'b1;
      tick();
      bus32.start = 1'b0;
      bus32.k_adv = 1'b1;
      for (int i = 0; i < 64; i++) begin
         expNext = 32'h0;
         if (i < 63) expNext = k256[i+1];
         total++;
         if (bus32.k_valid !== 1'b1 || bus32.busy !== 1'b1 || bus32.round_idx !== 7'(i) || bus32.k_out !== k256[i] ||
             bus32.k_next !== expNext || bus32.k_last !== (i == 63) || bus32.done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stream32 round %0d: got valid=%b idx=%0d kout=%h knext=%h last=%b done=%b want 1 %0d %h %h %b 0",
                     i, bus32.k_valid, bus32.round_idx, bus32.k_out, bus32.k_next, bus32.k_last, bus32.done,
                     i, k256[i], expNext, (i == 63));
         end
         tick();
      end
      total++;
      if (bus32.done !== 1'b1 || {bus32.k_valid, bus32.k_last, bus32.round_idx, bus32.k_out, bus32.k_next} !== '0) begin
         bad++;
         $display("[TB] FAIL stream32_done: got done=%b valid=%b idx=%0d kout=%h want done=1 others 0",
                  bus32.done, bus32.k_valid, bus32.round_idx, bus32.k_out);
      end
      tick();
      bus32.k_adv = 1'b0;
      total++;
      if (bus32.done !== 1'b0 || bus32.k_valid !== 1'b0 || bus32.k_out !== 32'h0) begin
         bad++;
         $display("[TB] FAIL stream32_after: got done=%b valid=%b kout=%h want 0 0 0 (no wrap)",
                  bus32.done, bus32.k_valid, bus32.k_out);
      end
   endtask

   // Stall at round 5 for four cycles; nothing may move until k_adv returns.
   task automatic test_stall();
      startAndAdvance32(5);
      total++;
      if (bus32.round_idx !== 7'd5 || bus32.k_out !== 32'h59f111f1 || bus32.k_next !== 32'h923f82a4) begin
         bad++;
         $display("[TB] FAIL stall_entry: got idx=%0d kout=%h knext=%h want 5 59f111f1 923f82a4",
                  bus32.round_idx, bus32.k_out, bus32.k_next);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (bus32.k_valid !== 1'b1 || bus32.round_idx !== 7'd5 || bus32.k_out !== 32'h59f111f1 ||
             bus32.k_next !== 32'h923f82a4 || bus32.k_last !== 1'b0 || bus32.done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_hold cycle %0d: got valid=%b idx=%0d kout=%h knext=%h want 1 5 59f111f1 923f82a4",
                     i, bus32.k_valid, bus32.round_idx, bus32.k_out, bus32.k_next);
         end
      end
      bus32.k_adv = 1'b1;
      tick();
      bus32.k_adv = 1'b0;
      total++;
      if (bus32.round_idx !== 7'd6 || bus32.k_out !== 32'h923f82a4 || bus32.k_next !== 32'hab1c5ed5) begin
         bad++;
         $display("[TB] FAIL stall_resume: got idx=%0d kout=%h knext=%h want 6 923f82a4 ab1c5ed5",
                  bus32.round_idx, bus32.k_out, bus32.k_next);
      end
      abort32();
   endtask

   // SHA-512 instance: full 80-word stream, accept count and done pulse.
   task automatic test_sha512();
      int          accepts;
      logic [63:0] expNext;
      accepts = 0;
      bus64.start = 1'b1;
      tick();
      bus64.start = 1'b0;
      bus64.k_adv = 1'b1;
      for (int i = 0; i < 80; i++) begin
         expNext = 64'h0;
         if (i < 79) expNext = k512[i+1];
         total++;
         if (bus64.k_valid !== 1'b1 || bus64.round_idx !== 7'(i) || bus64.k_out !== k512[i] ||
             bus64.k_next !== expNext || bus64.k_last !== (i == 79) || bus64.done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stream64 round %0d: got valid=%b idx=%0d kout=%h knext=%h last=%b want 1 %0d %h %h %b",
                     i, bus64.k_valid, bus64.round_idx, bus64.k_out, bus64.k_next, bus64.k_last,
                     i, k512[i], expNext, (i == 79));
         end
         if (bus64.k_valid === 1'b1) accepts++;
         tick();
      end
      bus64.k_adv = 1'b0;
      total++;
      if (bus64.done !== 1'b1 || bus64.k_valid !== 1'b0 || bus64.k_out !== 64'h0 || accepts !== 80) begin
         bad++;
         $display("[TB] FAIL stream64_done: got done=%b valid=%b kout=%h accepts=%0d want 1 0 0 80",
                  bus64.done, bus64.k_valid, bus64.k_out, accepts);
      end
      tick();
      total++;
      if (bus64.done !== 1'b0 || bus64.k_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL stream64_after: got done=%b valid=%b want 0 0", bus64.done, bus64.k_valid);
      end
   endtask

   // Abort mid-run, restart mid-run, and simultaneous start+abort.
   task automatic test_abort_restart();
      startAndAdvance32(20);
      bus32.abort = 1'b1;
      bus32.k_adv = 1'b1;
      tick();
      bus32.abort = 1'b0;
      bus32.k_adv = 1'b0;
      total++;
      if ({bus32.k_valid, bus32.done, bus32.round_idx, bus32.k_out, bus32.k_next} !== '0) begin
         bad++;
         $display("[TB] FAIL abort20: got valid=%b done=%b idx=%0d kout=%h want all 0",
                  bus32.k_valid, bus32.done, bus32.round_idx, bus32.k_out);
      end
      tick();
      total++;
      if (bus32.done !== 1'b0 || bus32.k_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort20_after: got done=%b valid=%b want 0 0", bus32.done, bus32.k_valid);
      end
      startAndAdvance32(30);
      bus32.start = 1'b1;
      bus32.k_adv = 1'b1;
      tick();
      bus32.start = 1'b0;
      bus32.k_adv = 1'b0;
      total++;
      if (bus32.k_valid !== 1'b1 || bus32.round_idx !== 7'd0 || bus32.k_out !== 32'h428a2f98 ||
          bus32.k_next !== 32'h71374491 || bus32.done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL restart30: got valid=%b idx=%0d kout=%h knext=%h done=%b want 1 0 428a2f98 71374491 0",
                  bus32.k_valid, bus32.round_idx, bus32.k_out, bus32.k_next, bus32.done);
      end
      bus32.start = 1'b1;
      bus32.abort = 1'b1;
      tick();
      bus32.start = 1'b0;
      bus32.abort = 1'b0;
      total++;
      if ({bus32.k_valid, bus32.done, bus32.round_idx, bus32.k_out, bus32.k_next} !== '0) begin
         bad++;
         $display("[TB] FAIL start_abort: got valid=%b done=%b idx=%0d kout=%h want all 0",
                  bus32.k_valid, bus32.done, bus32.round_idx, bus32.k_out);
      end
   endtask

   // Restart on the last word must not raise done; k_adv in idle does nothing.
   task automatic test_last_collision();
      startAndAdvance32(63);
      total++;
      if (bus32.k_last !== 1'b1 || bus32.round_idx !== 7'd63 || bus32.k_out !== 32'hc67178f2 || bus32.k_next !== 32'h0) begin
         bad++;
         $display("[TB] FAIL last_word: got last=%b idx=%0d kout=%h knext=%h want 1 63 c67178f2 0",
                  bus32.k_last, bus32.round_idx, bus32.k_out, bus32.k_next);
      end
      bus32.start = 1'b1;
      bus32.k_adv = 1'b1;
      tick();
      bus32.start = 1'b0;
      bus32.k_adv = 1'b0;
      total++;
      if (bus32.k_valid !== 1'b1 || bus32.round_idx !== 7'd0 || bus32.k_out !== 32'h428a2f98 || bus32.done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL last_restart: got valid=%b idx=%0d kout=%h done=%b want 1 0 428a2f98 0",
                  bus32.k_valid, bus32.round_idx, bus32.k_out, bus32.done);
      end
      tick();
      total++;
      if (bus32.done !== 1'b0 || bus32.round_idx !== 7'd0) begin
         bad++;
         $display("[TB] FAIL last_restart_after: got done=%b idx=%0d want 0 0", bus32.done, bus32.round_idx);
      end
      abort32();
      for (int i = 0; i < 3; i++) begin
         bus32.k_adv = 1'b1;
         tick();
         total++;
         if ({bus32.k_valid, bus32.done, bus32.round_idx, bus32.k_out, bus32.k_next} !== '0) begin
            bad++;
            $display("[TB] FAIL idle_adv %0d: got valid=%b done=%b idx=%0d kout=%h want all 0",
                     i, bus32.k_valid, bus32.done, bus32.round_idx, bus32.k_out);
         end
      end
      bus32.k_adv = 1'b0;
   endtask

   initial begin
      bus32.start = 1'b0;
      bus32.abort = 1'b0;
      bus32.k_adv = 1'b0;
      bus64.start = 1'b0;
      bus64.abort = 1'b0;
      bus64.k_adv = 1'b0;
      test_reset();
      test_full_stream32();
      test_stall();
      test_sha512();
      test_abort_restart();
      test_last_collision();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
